// File: rtl/spi_reg_responder.sv
// ---------------------------------------------------------------------------
// spi_reg_responder
//
// SPI mode-0 slave that fronts a small register file. A frame starts with CS
// low and a command word {RW, ..., addr}. RW=1 streams reg[addr] out on MISO,
// and RW=0 writes each following data word into reg[addr]. Extra words keep
// the transfer going. SCLK, MOSI and CS are asynchronous to Clock, so each
// one is brought in through a two-flop synchronizer. All logic runs on Clock.
//
// Optional feature (macro SPI_RESP_AUTOINC_EN):
//   defined   - the address advances by 1 after every data word and wraps
//               from 2**AW-1 to 0.
//   undefined - the address stays fixed for the whole frame.
//
// Parameters
//   DW  data/shift width; the command word is also DW bits (DW >= AW+1)
//   AW  register address width; the file holds 2**AW registers
//
// Ports
//   Clock     in   system clock
//   Reset     in   asynchronous active-low reset
//   SCLK      in   SPI clock from the master, idle low
//   MOSI      in   master-out data, MSB first
//   CS        in   chip select, active low
//   MISO      out  slave-out data, MSB first
//   busy      out  synchronized CS is asserted (frame in progress)
//   wr_stb    out  one-cycle pulse when an SPI write is committed
//   wr_addr   out  address of the committed SPI write
//   wr_data   out  data of the committed SPI write
//   hrd_addr  in   host read address
//   hrd_data  out  combinational read of reg[hrd_addr]
//   hwr_en    in   host write enable
//   hwr_addr  in   host write address
//   hwr_data  in   host write data
//   o_state   out  debug view of the frame FSM (0 IDLE, 1 CMD, 2 WR, 3 RD)
// ---------------------------------------------------------------------------
module spi_reg_responder #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          Clock,
   input  logic          Reset,
   input  logic          SCLK,
   input  logic          MOSI,
   input  logic          CS,
   output logic          MISO,
   output logic          busy,
   output logic          wr_stb,
   output logic [AW-1:0] wr_addr,
   output logic [DW-1:0] wr_data,
   input  logic [AW-1:0] hrd_addr,
   output logic [DW-1:0] hrd_data,
   input  logic          hwr_en,
   input  logic [AW-1:0] hwr_addr,
   input  logic [DW-1:0] hwr_data,
   output logic [1:0]    o_state
);

   localparam int CW = (DW > 1) ? $clog2(DW) : 1;
   localparam int NR = 2 ** AW;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      WR   = 2'd2,
      RD   = 2'd3
   } state_t;

   // Synchronizers and edge detection
   logic r_sclk_s1, r_sclk_s2, r_sclk_d;
   logic r_mosi_s1, r_mosi_s2;
   logic r_cs_s1, r_cs_s2;

   // CS resets high so that reset never looks like the start of a frame.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_sclk_s1 <= 1'b0;
         r_sclk_s2 <= 1'b0;
         r_sclk_d  <= 1'b0;
         r_mosi_s1 <= 1'b0;
         r_mosi_s2 <= 1'b0;
         r_cs_s1   <= 1'b1;
         r_cs_s2   <= 1'b1;
      end else begin
         r_sclk_s1 <= SCLK;
         r_sclk_s2 <= r_sclk_s1;
         r_sclk_d  <= r_sclk_s2;
         r_mosi_s1 <= MOSI;
         r_mosi_s2 <= r_mosi_s1;
         r_cs_s1   <= CS;
         r_cs_s2   <= r_cs_s1;
      end
   end

   logic w_rise, w_fall;
   assign w_rise = r_sclk_s2 & ~r_sclk_d;
   assign w_fall = ~r_sclk_s2 & r_sclk_d;

   // Frame state
   state_t          r_state;
   logic [CW-1:0]   r_bit_cnt;
   logic [DW-2:0]   r_shift_in;   // the newest bit is taken straight from MOSI
   logic [DW-2:0]   r_shift_out;  // the MSB in flight lives in r_miso
   logic [AW-1:0]   r_addr;
   logic            r_miso;
   logic            r_busy;
   logic            r_wr_stb;
   logic [AW-1:0]   r_wr_addr;
   logic [DW-1:0]   r_wr_data;
   logic [DW-1:0]   r_regs [NR];

   logic [DW-1:0]   w_byte;
   logic            w_last;
   logic [AW-1:0]   w_cmd_addr;
   logic [AW-1:0]   w_next_addr;
   logic [AW-1:0]   w_load_addr;
   logic [DW-1:0]   w_load_data;
   logic            w_spi_we;

   assign w_byte     = {r_shift_in, r_mosi_s2};
   assign w_last     = (r_bit_cnt == CW'(DW - 1));
   assign w_cmd_addr = w_byte[AW-1:0];

`ifdef SPI_RESP_AUTOINC_EN
   assign w_next_addr = r_addr + 1'b1;
`else
   assign w_next_addr = r_addr;
`endif

   // A read word is fetched either right after the command or at each word
   // boundary in RD. The value is captured at that moment, so later host
   // writes do not disturb the word being shifted out.
   assign w_load_addr = (r_state == CMD) ? w_cmd_addr : w_next_addr;
   assign w_load_data = r_regs[w_load_addr];

   // A write commits on the last rising edge of a data word, provided CS has
   // not already been seen high.
   assign w_spi_we = (r_state == WR) && !r_cs_s2 && w_rise && w_last;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_state     <= IDLE;
         r_bit_cnt   <= '0;
         r_shift_in  <= '0;
         r_shift_out <= '0;
         r_addr      <= '0;
         r_miso      <= 1'b0;
         r_busy      <= 1'b0;
         r_wr_stb    <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
      end else begin
         r_wr_stb <= 1'b0;
         r_busy   <= ~r_cs_s2;
         if (r_cs_s2) begin
            // CS high ends the frame at once and drops any partial word.
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_miso    <= 1'b0;
         end else begin
            if (w_rise) begin
               r_shift_in <= w_byte[DW-2:0];
               r_bit_cnt  <= w_last ? '0 : r_bit_cnt + 1'b1;
            end
            case (r_state)
               IDLE: begin
                  r_state   <= CMD;
                  r_bit_cnt <= '0;
                  r_miso    <= 1'b0;
               end
               CMD: begin
                  if (w_rise && w_last) begin
                     r_addr <= w_cmd_addr;
                     if (w_byte[DW-1]) begin
                        r_shift_out <= w_load_data[DW-2:0];
                        r_miso      <= w_load_data[DW-1];
                        r_state     <= RD;
                     end else begin
                        r_state <= WR;
                     end
                  end
               end
               WR: begin
                  if (w_spi_we) begin
                     r_wr_stb  <= 1'b1;
                     r_wr_addr <= r_addr;
                     r_wr_data <= w_byte;
                     r_addr    <= w_next_addr;
                  end
               end
               RD: begin
                  if (w_rise && w_last) begin
                     r_shift_out <= w_load_data[DW-2:0];
                     r_miso      <= w_load_data[DW-1];
                     r_addr      <= w_next_addr;
                  end else if (w_fall && (r_bit_cnt != '0)) begin
                     // The fall that follows a word boundary must not shift,
                     // because the new MSB has already been presented.
                     r_shift_out <= {r_shift_out[DW-3:0], 1'b0};
                     r_miso      <= r_shift_out[DW-2];
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   // Register file. On an address collision the SPI write takes priority.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < NR; i++) r_regs[i] <= '0;
      end else begin
         if (w_spi_we) r_regs[r_addr] <= w_byte;
         if (hwr_en && !(w_spi_we && (hwr_addr == r_addr)))
            r_regs[hwr_addr] <= hwr_data;
      end
   end

   assign MISO     = r_miso;
   assign busy     = r_busy;
   assign wr_stb   = r_wr_stb;
   assign wr_addr  = r_wr_addr;
   assign wr_data  = r_wr_data;
   assign hrd_data = r_regs[hrd_addr];
   assign o_state  = r_state;

endmodule

// File: tb/tb_spi_reg_responder.sv
// ---------------------------------------------------------------------------
// tb_spi_reg_responder
//
// Directed bench for spi_reg_responder (DW=8, AW=4). The bench acts as an SPI
// mode-0 master and uses SCLK half-periods of 6 Clock cycles. Expected values
// are worked out by hand from the protocol.
// ---------------------------------------------------------------------------
module tb_spi_reg_responder;

   logic       clk;
   logic       rst_n;
   logic       sclk;
   logic       mosi;
   logic       cs_n;
   logic       miso;
   logic       busy;
   logic       wr_stb;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic [3:0] hrd_addr;
   logic [7:0] hrd_data;
   logic       hwr_en;
   logic [3:0] hwr_addr;
   logic [7:0] hwr_data;
   logic [1:0] state;

   int checks   = 0;
   int failures = 0;

   spi_reg_responder #(.DW(8), .AW(4)) dut (
      .Clock    (clk),
      .Reset    (rst_n),
      .SCLK     (sclk),
      .MOSI     (mosi),
      .CS       (cs_n),
      .MISO     (miso),
      .busy     (busy),
      .wr_stb   (wr_stb),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .hrd_addr (hrd_addr),
      .hrd_data (hrd_data),
      .hwr_en   (hwr_en),
      .hwr_addr (hwr_addr),
      .hwr_data (hwr_data),
      .o_state  (state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write-strobe monitor: counts strobe cycles and keeps the last address and data
   int         stb_cnt = 0;
   logic [3:0] stb_addr = '0;
   logic [7:0] stb_data = '0;
   always @(posedge clk) begin
      if (wr_stb) begin
         stb_cnt  <= stb_cnt + 1;
         stb_addr <= wr_addr;
         stb_data <= wr_data;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Driver tasks
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic spi_bit(input logic b, output logic r);
      mosi = b;
      cyc(6);
      sclk = 1'b1;
      r = miso;
      cyc(6);
      sclk = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rxb);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(tx[i], b);
         rxb[i] = b;
      end
   endtask

   task automatic frame_begin();
      cs_n = 1'b0;
      cyc(6);
   endtask

   task automatic frame_end();
      cyc(6);
      cs_n = 1'b1;
      cyc(6);
   endtask

   task automatic host_write(input logic [3:0] a, input logic [7:0] d);
      hwr_addr = a;
      hwr_data = d;
      hwr_en   = 1'b1;
      cyc(1);
      hwr_en   = 1'b0;
   endtask

   task automatic check_reg(input string tag, input logic [3:0] a, input logic [7:0] exp);
      hrd_addr = a;
      #1;
      check(tag, 32'(hrd_data), 32'(exp));
   endtask

   // Single-word SPI write frame. A host write is placed in exactly the cycle
   // the SPI write commits. The synced rise is visible two edges after SCLK
   // goes high and is acted on at the third edge.
   task automatic spi_write_race(input logic [7:0] cmd, input logic [7:0] d,
                                 input logic [3:0] ha, input logic [7:0] hd);
      logic [7:0] rxb;
      logic       b;
      frame_begin();
      spi_byte(cmd, rxb);
      for (int i = 7; i >= 1; i--) spi_bit(d[i], b);
      mosi = d[0];
      cyc(6);
      sclk = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      hwr_addr = ha;
      hwr_data = hd;
      hwr_en   = 1'b1;
      @(posedge clk);
      #1;
      hwr_en   = 1'b0;
      cyc(4);
      sclk = 1'b0;
      frame_end();
   endtask

   // Directed sequence
   logic [7:0] rx, rx_cmd;
   logic       bit_rx;
   int         s0;

   initial begin
      rst_n    = 1'b0;
      sclk     = 1'b0;
      mosi     = 1'b0;
      cs_n     = 1'b1;
      hrd_addr = '0;
      hwr_en   = 1'b0;
      hwr_addr = '0;
      hwr_data = '0;
      cyc(2);

      // Reset state
      check("rst_miso",    32'(miso),    32'h0);
      check("rst_busy",    32'(busy),    32'h0);
      check("rst_wr_stb",  32'(wr_stb),  32'h0);
      check("rst_wr_addr", 32'(wr_addr), 32'h0);
      check("rst_wr_data", 32'(wr_data), 32'h0);
      check("rst_state",   32'(state),   32'h0);
      check_reg("rst_reg0", 4'd0, 8'h00);
      rst_n = 1'b1;
      cyc(3);

      // SPI write: cmd 0x03, data 0xA5
      s0 = stb_cnt;
      frame_begin();
      check("wr_busy_in_frame", 32'(busy), 32'h1);
      check("wr_state_cmd", 32'(state), 32'h1);
      spi_byte(8'h03, rx_cmd);
      spi_byte(8'hA5, rx);
      frame_end();
      check_reg("wr_reg3", 4'd3, 8'hA5);
      check("wr_stb_count", 32'(stb_cnt - s0), 32'd1);
      check("wr_stb_addr",  32'(stb_addr), 32'h3);
      check("wr_stb_data",  32'(stb_data), 32'hA5);
      check("wr_busy_after", 32'(busy), 32'h0);
      check("wr_state_idle", 32'(state), 32'h0);

      // Host write reg[5], SPI read cmd 0x85 and one dummy word
      host_write(4'd5, 8'h3C);
      s0 = stb_cnt;
      frame_begin();
      spi_byte(8'h85, rx_cmd);
      spi_byte(8'h00, rx);
      frame_end();
      check("rd_miso_during_cmd", 32'(rx_cmd), 32'h00);
      check("rd_data_reg5", 32'(rx), 32'h3C);
      check("rd_no_stb", 32'(stb_cnt - s0), 32'd0);

      // Two data words to address 15
      s0 = stb_cnt;
      frame_begin();
      spi_byte(8'h0F, rx_cmd);
      spi_byte(8'h11, rx);
      spi_byte(8'h22, rx);
      frame_end();
      check("multi_stb_count", 32'(stb_cnt - s0), 32'd2);
`ifdef SPI_RESP_AUTOINC_EN
      check_reg("autoinc_reg15", 4'd15, 8'h11);
      check_reg("autoinc_reg0",  4'd0,  8'h22);
`else
      check_reg("fixed_reg15", 4'd15, 8'h22);
      check_reg("fixed_reg0",  4'd0,  8'h00);
`endif

      // Aborted write: cmd 0x02, CS raised after 5 data bits
      host_write(4'd2, 8'h5A);
      s0 = stb_cnt;
      frame_begin();
      spi_byte(8'h02, rx_cmd);
      for (int i = 0; i < 5; i++) spi_bit(1'b1, bit_rx);
      cyc(6);
      cs_n = 1'b1;
      cyc(6);
      check_reg("abort_reg2", 4'd2, 8'h5A);
      check("abort_no_stb", 32'(stb_cnt - s0), 32'd0);
      check("abort_busy",   32'(busy),  32'h0);
      check("abort_state",  32'(state), 32'h0);

      // SPI commit and host write in the same cycle
      spi_write_race(8'h01, 8'h77, 4'd1, 8'h99);
      check_reg("race_same_reg1", 4'd1, 8'h77);
      spi_write_race(8'h07, 8'h42, 4'd8, 8'h24);
      check_reg("race_diff_reg7", 4'd7, 8'h42);
      check_reg("race_diff_reg8", 4'd8, 8'h24);

      // Reset in the middle of a read of reg[9]=0xD8 (bit4 = 1)
      host_write(4'd9, 8'hD8);
      frame_begin();
      spi_byte(8'h89, rx_cmd);
      for (int i = 0; i < 3; i++) spi_bit(1'b0, bit_rx);
      cyc(6);
      check("midrd_miso_bit4", 32'(miso), 32'h1);
      rst_n = 1'b0;
      #1;
      check("midrst_miso",  32'(miso),  32'h0);
      check("midrst_busy",  32'(busy),  32'h0);
      check("midrst_state", 32'(state), 32'h0);
      check_reg("midrst_reg9", 4'd9, 8'h00);
      check_reg("midrst_reg3", 4'd3, 8'h00);
      cs_n = 1'b1;
      cyc(3);
      rst_n = 1'b1;
      cyc(4);

      // Frames after reset decode normally
      host_write(4'd4, 8'h81);
      frame_begin();
      spi_byte(8'h84, rx_cmd);
      spi_byte(8'h00, rx);
      frame_end();
      check("post_rst_cmd_miso", 32'(rx_cmd), 32'h00);
      check("post_rst_rd_reg4",  32'(rx), 32'h81);
      s0 = stb_cnt;
      frame_begin();
      spi_byte(8'h0A, rx_cmd);
      spi_byte(8'h5C, rx);
      frame_end();
      check_reg("post_rst_wr_reg10", 4'd10, 8'h5C);
      check("post_rst_stb_addr", 32'(stb_addr), 32'hA);
      check("post_rst_stb_count", 32'(stb_cnt - s0), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
